// File: rtl/delay_line_seq.sv
// delay_line_seq: fill/stream sequencer for the DDS tapped delay line; `DLS_STALL_CNT_EN adds stall_cnt
module delay_line_seq #(
  parameter int DEPTH = 515,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_wr,
  input  logic [2:0]       cfg_len,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             sr_en,
  output logic             sr_clr,
  output logic [2:0]       tap_sel,
  output logic [CNT_W-1:0] fill_cnt,
  output logic             busy
`ifdef DLS_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, CLEAR, FILL, RUN} state_t;
  state_t state_q, state_d;
  logic m_valid_q, m_valid_d;
  logic [2:0] tap_sel_q, tap_sel_d;
  logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d, n_len;
  logic last;
`ifdef DLS_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
`endif
  // fill target for the registered length code; cfg_wr blocks the upstream handshake
  always_comb begin
    n_len   = tap_sel_q == 3'd7 ? CNT_W'(DEPTH) :
              tap_sel_q == 3'd0 ? CNT_W'(2) : CNT_W'(1) << ({1'b0, tap_sel_q} + 4'd2);
    last    = fill_cnt_q == n_len - CNT_W'(1);
    s_ready = !cfg_wr & ((state_q == FILL) | ((state_q == RUN) & (!m_valid_q | m_ready)));
    sr_en   = s_valid & s_ready;
    sr_clr  = state_q == CLEAR;
    busy    = (state_q == CLEAR) | (state_q == FILL);
  end
  // next state: cfg_wr restarts from any state, the sample completing the fill enters RUN
  always_comb begin
    state_d    = cfg_wr ? CLEAR :
                 state_q == CLEAR ? FILL :
                 (state_q == FILL) & sr_en & last ? RUN : state_q;
    fill_cnt_d = cfg_wr | (state_q == CLEAR) ? '0 :
                 sr_en & (fill_cnt_q < n_len) ? fill_cnt_q + CNT_W'(1) : fill_cnt_q;
    m_valid_d  = cfg_wr ? 1'b0 :
                 sr_en & ((state_q == RUN) | last) ? 1'b1 :
                 m_valid_q & m_ready ? 1'b0 : m_valid_q;
    tap_sel_d  = cfg_wr ? cfg_len : tap_sel_q;
`ifdef DLS_STALL_CNT_EN
    stall_cnt_d = cfg_wr ? 16'd0 :
                  (state_q == RUN) & s_valid & !s_ready & (stall_cnt_q != 16'hFFFF) ?
                  stall_cnt_q + 16'd1 : stall_cnt_q;
`endif
  end
  // all sequencer state, cleared asynchronously together with the delay line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      m_valid_q  <= 1'b0;
      tap_sel_q  <= 3'd0;
      fill_cnt_q <= '0;
`ifdef DLS_STALL_CNT_EN
      stall_cnt_q <= 16'd0;
`endif
    end else begin
      state_q    <= state_d;
      m_valid_q  <= m_valid_d;
      tap_sel_q  <= tap_sel_d;
      fill_cnt_q <= fill_cnt_d;
`ifdef DLS_STALL_CNT_EN
      stall_cnt_q <= stall_cnt_d;
`endif
    end
  end
  assign m_valid  = m_valid_q;
  assign tap_sel  = tap_sel_q;
  assign fill_cnt = fill_cnt_q;
`ifdef DLS_STALL_CNT_EN
  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_delay_line_seq.sv
// tb_delay_line_seq: directed bench for delay_line_seq; `DLS_STALL_CNT_EN also checks stall_cnt
module tb_delay_line_seq;
  logic clk = 1'b0, rst = 1'b1, cfg_wr = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
  logic [2:0] cfg_len = 3'd0;
  logic s_ready, m_valid, sr_en, sr_clr, busy;
  logic [2:0] tap_sel;
  logic [9:0] fill_cnt;
`ifdef DLS_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif
  int n_cmp = 0, n_err = 0;

  delay_line_seq dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_len(cfg_len),
    .s_valid(s_valid), .s_ready(s_ready), .m_valid(m_valid), .m_ready(m_ready),
    .sr_en(sr_en), .sr_clr(sr_clr), .tap_sel(tap_sel), .fill_cnt(fill_cnt), .busy(busy)
`ifdef DLS_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    s_valid = 1'b1;
    m_ready = 1'b1;
    #12;
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    n_cmp++; if (tap_sel !== 3'd0) begin n_err++; $display("FAIL reset_tap_sel got %0d want 0", tap_sel); end
    n_cmp++; if (fill_cnt !== 10'd0) begin n_err++; $display("FAIL reset_fill_cnt got %0d want 0", fill_cnt); end
    n_cmp++; if (sr_clr !== 1'b0) begin n_err++; $display("FAIL reset_sr_clr got %b want 0", sr_clr); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b0;
    tick;
    n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL idle_s_ready got %b want 0", s_ready); end
    n_cmp++; if (sr_en !== 1'b0) begin n_err++; $display("FAIL idle_sr_en got %b want 0", sr_en); end
  endtask

  task automatic test_fill8;
    cfg_wr = 1'b1;
    cfg_len = 3'd1;
    #1;
    n_cmp++; if (sr_en !== 1'b0) begin n_err++; $display("FAIL cfg_sr_en got %b want 0", sr_en); end
    tick;
    cfg_wr = 1'b0;
    #1;
    n_cmp++; if (sr_clr !== 1'b1) begin n_err++; $display("FAIL clear_sr_clr got %b want 1", sr_clr); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL clear_busy got %b want 1", busy); end
    n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL clear_s_ready got %b want 0", s_ready); end
    n_cmp++; if (tap_sel !== 3'd1) begin n_err++; $display("FAIL clear_tap_sel got %0d want 1", tap_sel); end
    tick;
    n_cmp++; if (sr_clr !== 1'b0) begin n_err++; $display("FAIL fill_sr_clr got %b want 0", sr_clr); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (fill_cnt !== 10'(i)) begin n_err++; $display("FAIL fill8_cnt got %0d want %0d", fill_cnt, i); end
      n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL fill8_m_valid_early got %b want 0 at %0d", m_valid, i); end
      n_cmp++; if (sr_en !== 1'b1) begin n_err++; $display("FAIL fill8_sr_en got %b want 1", sr_en); end
      tick;
    end
    n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL fill8_m_valid got %b want 1", m_valid); end
    n_cmp++; if (fill_cnt !== 10'd8) begin n_err++; $display("FAIL fill8_final_cnt got %0d want 8", fill_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL run_busy got %b want 0", busy); end
  endtask

  task automatic test_stall;
    m_ready = 1'b0;
    #1;
    n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL stall_s_ready got %b want 0", s_ready); end
    for (int i = 0; i < 5; i++) begin
      tick;
      n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL stall_m_valid got %b want 1", m_valid); end
      n_cmp++; if (sr_en !== 1'b0) begin n_err++; $display("FAIL stall_sr_en got %b want 0", sr_en); end
      n_cmp++; if (fill_cnt !== 10'd8) begin n_err++; $display("FAIL stall_fill_cnt got %0d want 8", fill_cnt); end
    end
    m_ready = 1'b1;
    #1;
    n_cmp++; if (sr_en !== 1'b1) begin n_err++; $display("FAIL resume_sr_en got %b want 1", sr_en); end
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL resume_m_valid got %b want 1", m_valid); end
      n_cmp++; if (sr_en !== 1'b1) begin n_err++; $display("FAIL resume_sr_en2 got %b want 1", sr_en); end
    end
    s_valid = 1'b0;
    tick;
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL drain_m_valid got %b want 0", m_valid); end
    n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL drain_s_ready got %b want 1", s_ready); end
  endtask

  task automatic test_cfg_mid_fill;
    int hs, cyc;
    s_valid = 1'b1;
    m_ready = 1'b0;
    tick;
    n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL pend_m_valid got %b want 1", m_valid); end
    cfg_wr = 1'b1;
    cfg_len = 3'd2;
    #1;
    n_cmp++; if (sr_en !== 1'b0) begin n_err++; $display("FAIL cfgrun_sr_en got %b want 0", sr_en); end
    tick;
    cfg_len = 3'd3;
    #1;
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL cfgrun_drop got %b want 0", m_valid); end
    n_cmp++; if (tap_sel !== 3'd2) begin n_err++; $display("FAIL cfgrun_tap_sel got %0d want 2", tap_sel); end
    tick;
    cfg_wr = 1'b0;
    m_ready = 1'b1;
    #1;
    n_cmp++; if (sr_clr !== 1'b1) begin n_err++; $display("FAIL reclear_sr_clr got %b want 1", sr_clr); end
    n_cmp++; if (tap_sel !== 3'd3) begin n_err++; $display("FAIL reclear_tap_sel got %0d want 3", tap_sel); end
    tick;
    for (int i = 0; i < 5; i++) tick;
    n_cmp++; if (fill_cnt !== 10'd5) begin n_err++; $display("FAIL mid_fill_cnt got %0d want 5", fill_cnt); end
    cfg_wr = 1'b1;
    cfg_len = 3'd1;
    #1;
    n_cmp++; if (sr_en !== 1'b0) begin n_err++; $display("FAIL midcfg_sr_en got %b want 0", sr_en); end
    tick;
    cfg_wr = 1'b0;
    #1;
    n_cmp++; if (fill_cnt !== 10'd0) begin n_err++; $display("FAIL midcfg_fill_cnt got %0d want 0", fill_cnt); end
    n_cmp++; if (sr_clr !== 1'b1) begin n_err++; $display("FAIL midcfg_sr_clr got %b want 1", sr_clr); end
    tick;
    hs = 0;
    cyc = 0;
    while (hs < 8 && cyc < 40) begin
      s_valid = (cyc % 2) == 0;
      #1;
      n_cmp++; if (fill_cnt !== 10'(hs)) begin n_err++; $display("FAIL refill_cnt got %0d want %0d", fill_cnt, hs); end
      n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL refill_m_valid got %b want 0", m_valid); end
      n_cmp++; if (sr_en !== s_valid) begin n_err++; $display("FAIL refill_sr_en got %b want %b", sr_en, s_valid); end
      hs += int'(s_valid);
      cyc++;
      tick;
    end
    s_valid = 1'b0;
    #1;
    n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL refill_done got %b want 1", m_valid); end
    n_cmp++; if (fill_cnt !== 10'd8) begin n_err++; $display("FAIL refill_final got %0d want 8", fill_cnt); end
  endtask

  task automatic test_len7;
    int hs, cyc;
    cfg_wr = 1'b1;
    cfg_len = 3'd7;
    tick;
    cfg_wr = 1'b0;
    tick;
    hs = 0;
    cyc = 0;
    while (hs < 515 && cyc < 2000) begin
      s_valid = (cyc % 3) != 2;
      #1;
      n_cmp++; if (fill_cnt !== 10'(hs)) begin n_err++; $display("FAIL len7_cnt got %0d want %0d", fill_cnt, hs); end
      n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL len7_m_valid_early got %b at hs %0d", m_valid, hs); end
      hs += int'(s_valid);
      cyc++;
      tick;
    end
    n_cmp++; if (hs != 515) begin n_err++; $display("FAIL len7_timeout got %0d handshakes want 515", hs); end
    s_valid = 1'b1;
    #1;
    n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL len7_m_valid got %b want 1", m_valid); end
    n_cmp++; if (fill_cnt !== 10'd515) begin n_err++; $display("FAIL len7_cnt_final got %0d want 515", fill_cnt); end
    for (int i = 0; i < 10; i++) tick;
    n_cmp++; if (fill_cnt !== 10'd515) begin n_err++; $display("FAIL len7_sat got %0d want 515", fill_cnt); end
  endtask

  task automatic test_rst_run;
    n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL prerst_m_valid got %b want 1", m_valid); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rst_m_valid got %b want 0", m_valid); end
    n_cmp++; if (fill_cnt !== 10'd0) begin n_err++; $display("FAIL rst_fill_cnt got %0d want 0", fill_cnt); end
    n_cmp++; if (tap_sel !== 3'd0) begin n_err++; $display("FAIL rst_tap_sel got %0d want 0", tap_sel); end
    #2;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL postrst_s_ready got %b want 0", s_ready); end
      n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL postrst_m_valid got %b want 0", m_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL postrst_busy got %b want 0", busy); end
    end
    cfg_wr = 1'b1;
    cfg_len = 3'd0;
    tick;
    cfg_wr = 1'b0;
    #1;
    n_cmp++; if (sr_clr !== 1'b1) begin n_err++; $display("FAIL postrst_clear got %b want 1", sr_clr); end
  endtask

`ifdef DLS_STALL_CNT_EN
  task automatic test_stall_cnt;
    cfg_wr = 1'b1;
    cfg_len = 3'd0;
    s_valid = 1'b1;
    m_ready = 1'b1;
    tick;
    cfg_wr = 1'b0;
    tick;
    tick;
    tick;
    n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL stallcnt_init got %0d want 0", stall_cnt); end
    n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL stallcnt_run got %b want 1", m_valid); end
    m_ready = 1'b0;
    tick;
    tick;
    tick;
    n_cmp++; if (stall_cnt !== 16'd3) begin n_err++; $display("FAIL stallcnt_3 got %0d want 3", stall_cnt); end
    cfg_wr = 1'b1;
    tick;
    cfg_wr = 1'b0;
    n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL stallcnt_clr got %0d want 0", stall_cnt); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_fill8;
    test_stall;
    test_cfg_mid_fill;
    test_len7;
    test_rst_run;
`ifdef DLS_STALL_CNT_EN
    test_stall_cnt;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
